// File: rtl/ysyx_22041405_alu_pkg.sv
// Shared definitions for the two-port ALU arbiter: one-hot opcodes, FSM states,
// latched control bundle and an opcode legality helper.
package ysyx_22041405_alu_pkg;

  localparam int OPCODE_W = 8;

  // One-hot ALU selects, MSB first: {add,lshift,slt,rshift,direct,and,or,xor}.
  // add_or_sub=1 selects subtract; u_or_s=1 selects signed slt / arithmetic rshift.
  // direct passes src2 through unchanged.
  localparam logic [OPCODE_W-1:0] ALUADD    = 8'h80;
  localparam logic [OPCODE_W-1:0] ALULSHIFT = 8'h40;
  localparam logic [OPCODE_W-1:0] ALUSLT    = 8'h20;
  localparam logic [OPCODE_W-1:0] ALURSHIFT = 8'h10;
  localparam logic [OPCODE_W-1:0] ALUDIRECT = 8'h08;
  localparam logic [OPCODE_W-1:0] ALUAND    = 8'h04;
  localparam logic [OPCODE_W-1:0] ALUOR     = 8'h02;
  localparam logic [OPCODE_W-1:0] ALUXOR    = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic                add_or_sub;
    logic                u_or_s;
  } alu_ctrl_t;

  function automatic logic is_onehot8(input logic [OPCODE_W-1:0] v);
    logic [OPCODE_W-1:0] vm1;
    vm1 = v - 8'd1;
    return (v != '0) && ((v & vm1) == '0);
  endfunction

endpackage

// File: rtl/ysyx_22041405_alu_arb_alu.sv
// Combinational one-hot ALU. Any opcode that is not exactly one-hot yields
// zero and raises err.
module ysyx_22041405_ALU
  import ysyx_22041405_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]    src1,
  input  logic [WIDTH-1:0]    src2,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                add_or_sub,
  input  logic                u_or_s,
  output logic [WIDTH-1:0]    result,
  output logic                err
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] src1_s;
  logic signed [WIDTH-1:0] src2_s;
  logic signed [WIDTH-1:0] sra_s;
  logic [WIDTH-1:0]        srl_u;
  logic                    lt;

  always_comb begin
    shamt  = src2[SHW-1:0];
    src1_s = src1;
    src2_s = src2;
    sra_s  = src1_s >>> shamt;
    srl_u  = src1 >> shamt;
    lt     = u_or_s ? (src1_s < src2_s) : (src1 < src2);
  end

  always_comb begin
    result = '0;
    case (opcode)
      ALUADD:    result = add_or_sub ? (src1 - src2) : (src1 + src2);
      ALULSHIFT: result = src1 << shamt;
      ALUSLT:    result = {{(WIDTH-1){1'b0}}, lt};
      ALURSHIFT: result = u_or_s ? sra_s : srl_u;
      ALUDIRECT: result = src2;
      ALUAND:    result = src1 & src2;
      ALUOR:     result = src1 | src2;
      ALUXOR:    result = src1 ^ src2;
      default:   result = '0;
    endcase
  end

  assign err = !is_onehot8(opcode);

endmodule

// File: rtl/ysyx_22041405_alu_arb.sv
// Two-requester round-robin front end for a single ALU. Each operation walks
// IDLE -> EXEC -> RESP; the result is held until the owner consumes it.
module ysyx_22041405_alu_arb
  import ysyx_22041405_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                p0_req_valid,
  output logic                p0_req_ready,
  input  logic [WIDTH-1:0]    p0_src1,
  input  logic [WIDTH-1:0]    p0_src2,
  input  logic [OPCODE_W-1:0] p0_opcode,
  input  logic                p0_add_or_sub,
  input  logic                p0_u_or_s,
  output logic                p0_rsp_valid,
  input  logic                p0_rsp_ready,
  output logic [WIDTH-1:0]    p0_result,
  output logic                p0_rsp_err,

  input  logic                p1_req_valid,
  output logic                p1_req_ready,
  input  logic [WIDTH-1:0]    p1_src1,
  input  logic [WIDTH-1:0]    p1_src2,
  input  logic [OPCODE_W-1:0] p1_opcode,
  input  logic                p1_add_or_sub,
  input  logic                p1_u_or_s,
  output logic                p1_rsp_valid,
  input  logic                p1_rsp_ready,
  output logic [WIDTH-1:0]    p1_result,
  output logic                p1_rsp_err,

  output logic                busy,
  output logic [31:0]         op_cnt
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [31:0]      op_cnt_q, op_cnt_d;

  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  alu_ctrl_t        ctrl_q, ctrl_d;

  logic             any_req;
  logic             grant;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] alu_result;
  logic             alu_err;

  // Grant follows ptr only under contention; a lone requester always wins.
  always_comb begin
    any_req = p0_req_valid | p1_req_valid;
    grant   = (p0_req_valid && p1_req_valid) ? ptr_q : p1_req_valid;
    accept  = (state_q == IDLE) && any_req;
    rsp_hs  = (state_q == RESP) && (owner_q ? p1_rsp_ready : p0_rsp_ready);
  end

  always_comb begin
    src1_d = grant ? p1_src1 : p0_src1;
    src2_d = grant ? p1_src2 : p0_src2;
    ctrl_d = grant ? '{opcode: p1_opcode, add_or_sub: p1_add_or_sub, u_or_s: p1_u_or_s}
                   : '{opcode: p0_opcode, add_or_sub: p0_add_or_sub, u_or_s: p0_u_or_s};
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    result_d = result_q;
    err_d    = err_q;
    op_cnt_d = op_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          owner_d = grant;
          ptr_d   = ~grant;
        end
      end
      EXEC: begin
        result_d = alu_result;
        err_d    = alu_err;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          state_d  = IDLE;
          op_cnt_d = op_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      err_q    <= err_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  // Operand latches carry no reset; they are only observed during EXEC.
  always_ff @(posedge clk) begin
    if (accept) begin
      src1_q <= src1_d;
      src2_q <= src2_d;
      ctrl_q <= ctrl_d;
    end
  end

  ysyx_22041405_ALU #(
    .WIDTH(WIDTH)
  ) u_alu (
    .src1       (src1_q),
    .src2       (src2_q),
    .opcode     (ctrl_q.opcode),
    .add_or_sub (ctrl_q.add_or_sub),
    .u_or_s     (ctrl_q.u_or_s),
    .result     (alu_result),
    .err        (alu_err)
  );

  // Handshake outputs are forced low while reset is asserted.
  always_comb begin
    p0_req_ready = rst_n && (state_q == IDLE) && any_req && (grant == 1'b0);
    p1_req_ready = rst_n && (state_q == IDLE) && any_req && (grant == 1'b1);
    p0_rsp_valid = rst_n && (state_q == RESP) && (owner_q == 1'b0);
    p1_rsp_valid = rst_n && (state_q == RESP) && (owner_q == 1'b1);
    busy         = rst_n && (state_q != IDLE);
    p0_result    = result_q;
    p1_result    = result_q;
    p0_rsp_err   = err_q;
    p1_rsp_err   = err_q;
    op_cnt       = op_cnt_q;
  end

endmodule
